// File: rtl/leb128_pkg.sv
// Shared types and constants for the unsigned LEB128 encoder.
// Only the u32 flavour is covered, so the packed image is 5 bytes wide.
package leb128_pkg;

    localparam int LEB128_U32_MAX_BYTES = 5;
    localparam int LEB128_CONT_BIT      = 7;
    localparam int LEB128_PK_W          = 8 * LEB128_U32_MAX_BYTES;

    typedef logic [7:0] leb_byte_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_t;

endpackage

// File: rtl/leb128_stream_encoder_pack_u32.sv
// Combinational u32 -> LEB128 packer: byte k sits at packed_val[8k +: 8], byte_len is 1..5.
// Zero latency, no flow control; the caller decides when to latch the result.
module pack_u32
    import leb128_pkg::*;
(
    input  logic [31:0]            data_in,
    output logic [LEB128_PK_W-1:0] packed_val,
    output logic [2:0]             byte_len
);

    // more[k] is set when the value needs a byte beyond byte k
    logic [3:0] more;

    always_comb begin
        more[0] = |data_in[31:7];
        more[1] = |data_in[31:14];
        more[2] = |data_in[31:21];
        more[3] = |data_in[31:28];

        byte_len = 3'd1 + {2'b00, more[0]} + {2'b00, more[1]}
                        + {2'b00, more[2]} + {2'b00, more[3]};

        packed_val = '0;
        for (int k = 0; k < LEB128_U32_MAX_BYTES - 1; k++) begin
            packed_val[8*k +: 7]                = data_in[7*k +: 7];
            packed_val[8*k + LEB128_CONT_BIT]   = more[k];
        end
        packed_val[LEB128_PK_W-8 +: 8] = {4'b0000, data_in[31:28]};
    end

endmodule

// File: rtl/leb128_stream_encoder.sv
// Streaming u32 LEB128 serializer: one word in, one encoded byte out per cycle.
// First byte one cycle after accept; out_ready low freezes the byte and blocks new words.
module leb128_stream_encoder
    import leb128_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] byte_cnt,
    output logic [CNT_W-1:0] word_cnt
);

    enc_state_t             state_q, state_d;
    logic [LEB128_PK_W-1:0] pk_q, pk_d;
    logic [2:0]             len_q, len_d;
    logic [2:0]             idx_q, idx_d;
    logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;

    logic [LEB128_PK_W-1:0] pk_w;
    logic [2:0]             len_w;
    logic                   xfer;
    logic                   accept;

    pack_u32 u_pack (
        .data_in    (in_data),
        .packed_val (pk_w),
        .byte_len   (len_w)
    );

    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign out_byte  = pk_q[{idx_q, 3'b000} +: 8];
    assign out_last  = (idx_q == len_q - 3'd1);
    assign byte_cnt  = byte_cnt_q;
    assign word_cnt  = word_cnt_q;

    assign xfer     = out_valid & out_ready;
    // A word may enter on the last byte's cycle so varints run back to back
    assign in_ready = rst_n & ~clr & ((state_q == IDLE) | (xfer & out_last));
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        pk_d       = pk_q;
        len_d      = len_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;

        if (clr) begin
            state_d    = IDLE;
            byte_cnt_d = '0;
            word_cnt_d = '0;
        end else begin
            if (xfer) begin
                byte_cnt_d = byte_cnt_q + 1'b1;
                if (!out_last) begin
                    idx_d = idx_q + 3'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            if (accept) begin
                state_d    = EMIT;
                pk_d       = pk_w;
                len_d      = len_w;
                idx_d      = 3'd0;
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pk_q       <= '0;
            len_q      <= 3'd0;
            idx_q      <= 3'd0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pk_q       <= pk_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

endmodule

// File: tb/tb_leb128_stream_encoder.sv
// Scoreboard bench for leb128_stream_encoder: expected bytes queued at accept, popped per transfer.
module tb_leb128_stream_encoder;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_byte;
    logic             out_last;
    logic             busy;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] word_cnt;

    leb128_stream_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .busy      (busy),
        .byte_cnt  (byte_cnt),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       last;
        logic [7:0] b;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_bytes = 0;
    int   exp_words = 0;
    int   cyc = 0;
    int   n_xfer = 0;
    int   n_stall = 0;
    int   busy_cyc = 0;
    int   xfer_first = -1;
    int   xfer_last = -1;
    bit   stop_tgl = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference LEB128 encoding, built independently of the packer
    task automatic push_exp(input logic [31:0] v);
        logic [31:0] r;
        exp_t        e;
        r = v;
        exp_words++;
        do begin
            e.b    = {1'b0, r[6:0]};
            r      = r >> 7;
            e.last = (r == 0);
            if (!e.last) e.b[7] = 1'b1;
            q.push_back(e);
            exp_bytes++;
        end while (!e.last);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: samples 3 time units after the falling edge, inputs are settled by then
    initial forever begin
        exp_t e;
        @(negedge clk);
        #3;
        if (busy) busy_cyc++;
        if (rst_n && !clr && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_byte", {24'd0, out_byte}, 32'hFFFF_FFFF);
            end else if (out_ready) begin
                e = q.pop_front();
                chk("out_byte", {24'd0, out_byte}, {24'd0, e.b});
                chk("out_last", {31'd0, out_last}, {31'd0, e.last});
                chk("in_ready_on_xfer", {31'd0, in_ready}, {31'd0, e.last});
                n_xfer++;
                if (xfer_first < 0) xfer_first = cyc;
                xfer_last = cyc;
            end else begin
                n_stall++;
                chk("stall_byte", {24'd0, out_byte}, {24'd0, q[0].b});
                chk("stall_last", {31'd0, out_last}, {31'd0, q[0].last});
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            end
        end
    end

    // Entered just after a falling edge; returns just after a falling edge
    task automatic send(input logic [31:0] v);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int i = 0; i < 200 && !done; i++) begin
            #4;
            if (in_ready) begin
                push_exp(v);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) chk("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            #4;
            if (q.size() == 0 && !out_valid) done = 1'b1;
        end
        @(negedge clk);
        if (!done) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_byte_cnt"}, {28'd0, byte_cnt}, exp_bytes % (1 << CNT_W));
        chk({tag, "_word_cnt"}, {28'd0, word_cnt}, exp_words % (1 << CNT_W));
    endtask

    task automatic reset_model();
        q.delete();
        exp_bytes = 0;
        exp_words = 0;
    endtask

    initial begin
        bit pat[4];
        int start;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_counters("rst");
        @(negedge clk);

        // Single-byte zero
        busy_cyc = 0;
        send(32'd0);
        in_valid = 1'b0;
        drain();
        chk("zero_busy_cycles", busy_cyc, 32'd1);
        check_counters("zero");

        // Two- and five-byte values
        send(32'd300);
        in_valid = 1'b0;
        drain();
        send(32'hFFFF_FFFF);
        in_valid = 1'b0;
        drain();
        check_counters("multi");

        // Back-to-back: 7F | 80 01 | 80 80 01 with no bubble
        xfer_first = -1;
        start = n_xfer;
        send(32'd127);
        send(32'd128);
        send(32'd16384);
        in_valid = 1'b0;
        drain();
        chk("b2b_bytes", n_xfer - start, 32'd6);
        chk("b2b_span", xfer_last - xfer_first + 1, 32'd6);
        check_counters("b2b");

        // Backpressure with out_ready pattern 1,0,0,1
        n_stall = 0;
        stop_tgl = 1'b0;
        fork
            begin
                send(32'h0FFF_FFFF);
                in_valid = 1'b0;
                drain();
                stop_tgl = 1'b1;
            end
            begin
                int i = 0;
                while (!stop_tgl) begin
                    out_ready = pat[i % 4];
                    i++;
                    @(negedge clk);
                end
            end
        join
        out_ready = 1'b1;
        chk("stall_seen", {31'd0, (n_stall > 0)}, 32'd1);
        check_counters("bp");

        // Reset after two bytes of a five-byte varint
        start = n_xfer;
        send(32'hFFFF_FFFF);
        in_valid = 1'b0;
        for (int i = 0; i < 50 && (n_xfer - start) < 2; i++) @(negedge clk);
        chk("rst_mid_progress", n_xfer - start, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mid_byte_cnt", {28'd0, byte_cnt}, 32'd0);
        chk("rst_mid_word_cnt", {28'd0, word_cnt}, 32'd0);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'd1);
        in_valid = 1'b0;
        drain();
        check_counters("post_rst");

        // 15 more one-byte words: byte_cnt wraps to 0
        for (int i = 0; i < 15; i++) send(i + 2);
        in_valid = 1'b0;
        drain();
        chk("wrap_byte_cnt", {28'd0, byte_cnt}, 32'd0);
        check_counters("wrap");

        // clr during a three-byte varint with a word waiting
        start = n_xfer;
        send(32'd16384);
        in_valid = 1'b0;
        for (int i = 0; i < 50 && (n_xfer - start) < 1; i++) @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd5;
        #4;
        chk("clr_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        reset_model();
        #3;
        chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_byte_cnt", {28'd0, byte_cnt}, 32'd0);
        chk("clr_word_cnt", {28'd0, word_cnt}, 32'd0);
        @(negedge clk);
        send(32'd300);
        in_valid = 1'b0;
        drain();
        check_counters("post_clr");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/leb128_stream_encoder.md
Name: leb128_stream_encoder

Overview:
Streaming LEB128 serializer for unsigned 32-bit values. It accepts one u32 word per valid/ready handshake and packs it with the existing combinational packer. It then emits the encoded varint one byte per cycle on a valid/ready byte stream, with no inter-word bubbles. It sits between word producers (e.g. section/field writers) and the byte-oriented output buffer.

Parameters:
CNT_W, 16, width of the wrapping emitted-byte and encoded-word statistic counters

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous soft clear: abort current varint, zero counters
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word this cycle
in_data  input  32  unsigned value to encode
out_valid  output  1  out_byte valid
out_ready  input  1  downstream accepts byte
out_byte  output  8  current encoded byte, LSB group first
out_last  output  1  out_byte is final byte of the varint (continuation bit 0)
busy  output  1  varint in flight (state == EMIT)
byte_cnt  output  CNT_W  bytes emitted since reset/clr, wraps modulo 2^CNT_W
word_cnt  output  CNT_W  words accepted since reset/clr, wraps

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- FSM states are IDLE and EMIT.
- Registers:
  - pk[39:0]: latched packer output.
  - len[2:0]: byte count, 1..5.
  - idx[2:0]: current byte index.
- Reset values: state IDLE, out_valid 0, out_byte 0, out_last 0, busy 0, byte_cnt 0, word_cnt 0, idx 0, len 0, pk 0.
- in_ready is combinational: rst_n & ~clr & (state==IDLE | (out_valid & out_ready & out_last)).
- Accept occurs when in_valid & in_ready. Next cycle:
  - state = EMIT, pk = packed(in_data), len = byte_len(in_data), idx = 0.
  - word_cnt increments.
- Latency: the first byte is valid on the cycle after accept.
- Throughput: a value needing N bytes occupies exactly N output cycles when out_ready is held at 1.
- In EMIT:
  - out_valid = 1.
  - out_byte = pk[8*idx +: 8], driven from registers.
  - out_last = (idx == len-1).
- Byte transfer (out_valid & out_ready): byte_cnt increments.
  - Not last: idx increments.
  - Last with a simultaneous accept: reload, stay in EMIT, no bubble.
  - Last with no accept: return to IDLE, out_valid 0.
- Backpressure: while out_valid & ~out_ready, out_byte, out_last and idx are held stable. No new word is accepted.
- Byte-length rule: len = 1 + (v>=2^7) + (v>=2^14) + (v>=2^21) + (v>=2^28).
  - Byte k has bit7 = 1 for k < len-1.
  - The 5th byte carries only v[31:28]; its upper nibble is 0.
- clr:
  - Next state IDLE, out_valid 0, counters 0.
  - Any partially emitted varint is dropped.
  - clr has priority over accept (in_ready = 0 while clr = 1) and over a simultaneous byte transfer; that byte is not counted.
- Reset mid-varint: all outputs return immediately to reset values and the in-flight word is lost. in_ready is 0 while rst_n is low.
- Counters wrap silently from 2^CNT_W-1 to 0.
- Idle outputs: out_byte and out_last keep their last values. They are don't-care when out_valid = 0; the bench must not check them then.

Decomposition:
- Shared package leb128_pkg:
  - LEB128_U32_MAX_BYTES = 5.
  - LEB128_CONT_BIT = 7.
  - Typedef leb_byte_t (8-bit).
  - Enum enc_state_t {IDLE, EMIT}.
- Sub-module: instantiate the existing combinational u32 packer, pack_u32 (data_in to packed_val/byte_len), on in_data. Do not duplicate the length logic.

Test Plan:
- Encode 0 with out_ready=1 -> one byte 0x00, out_last=1; byte_cnt=1, word_cnt=1; busy for 1 cycle.
- Encode 300 (0x12C), then 0xFFFFFFFF, out_ready=1 -> bytes AC 02 then FF FF FF FF 0F. out_last only on 02 and 0F.
- Back-to-back in_valid with 127, 128, 16384, out_ready=1:
  - Expect 7F | 80 01 | 80 80 01 on 6 consecutive cycles, no idle cycle between varints.
  - in_ready pulses only on last-byte cycles.
- Encode 0x0FFFFFFF with out_ready toggling 1,0,0,1,... -> FF FF FF 7F. Each byte held stable while stalled; in_ready=0 throughout the stall.
- Accept 0xFFFFFFFF, then assert rst_n=0 after 2 bytes -> out_valid drops asynchronously, counters 0. After release, encode 1 -> single byte 01.
- Counter wrap and clr:
  - With CNT_W=4, encode 16 one-byte values -> byte_cnt wraps to 0.
  - Then assert clr during a 3-byte varint with in_valid=1 -> no accept, out_valid=0 next cycle, counters 0.
